// File: rtl/pipeline_pkg.sv
// +-----------------------------------------------------------------------+
// | pipeline_pkg : shared types and default bus widths for stage registers |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  // Encoding doubles as {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } stage_state_t;

  localparam int PERF_CNT_W = 32;

  localparam int IF_ID_W  = 96;
  localparam int ID_EX_W  = 294;
  localparam int EX_MEM_W = 160;
  localparam int MEM_WB_W = 104;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// +-----------------------------------------------------------------------+
// | pipe_sat_counter : up-counter with increment enable, sticks at max     |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module pipe_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +-----------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register, 2-entry skid, flush.   |
// | PIPE_STAGE_PERF_EN adds stall_cycles / flush_count counters.           |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int               WIDTH         = ID_EX_W,
  parameter int               PRESERVE_LSBS = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_count,
`endif
  output logic [WIDTH-1:0]      out_data
);

  // Ones in the low PRESERVE_LSBS positions; these bits survive a flush.
  localparam logic [WIDTH-1:0] KEEP_MASK = ~({WIDTH{1'b1}} << PRESERVE_LSBS);

  stage_state_t     state;
  stage_state_t     state_nxt;
  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid_in;

  assign in_ready  = ~skid_valid & ~reset;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = ONE;
        ONE: begin
          if (in_fire && !out_fire) state_nxt = FULL;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        FULL:    if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_valid     = state[1];
    skid_valid     = state[0];
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      EMPTY: load_main_in = in_fire;
      ONE: begin
        load_main_in = in_fire & out_fire;
        load_skid_in = in_fire & ~out_fire;
      end
      FULL:    load_main_skid = out_fire;
      default: ;
    endcase
  end

  // Flush wins over any transfer in the same cycle; it only trims data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= RESET_VALUE;
      skid_data <= RESET_VALUE;
    end else if (flush) begin
      main_data <= main_data & KEEP_MASK;
      skid_data <= skid_data & KEEP_MASK;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_valid & ~out_ready;
  assign flush_inc = flush & main_valid;

  pipe_sat_counter #(
    .WIDTH(PERF_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_inc),
    .count(stall_cycles)
  );

  pipe_sat_counter #(
    .WIDTH(PERF_CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (flush_inc),
    .count(flush_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +-----------------------------------------------------------------------+
// | tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg   |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;

  localparam int W = 294;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  flush_count;
`endif

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH        (W),
    .PRESERVE_LSBS(1),
    .RESET_VALUE  ('0)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cycles(stall_cycles),
    .flush_count (flush_count),
`endif
    .out_data    (out_data)
  );

  // Upstream contract: a presented, unaccepted payload stays put (reset/flush excuse it).
  logic         pend = 1'b0;
  logic [W-1:0] pend_data;
  always @(posedge clk) begin
    if (pend && !reset && (in_valid !== 1'b1 || in_data !== pend_data))
      $error("upstream payload changed before acceptance");
    pend      <= in_valid & ~in_ready & ~flush & ~reset;
    pend_data <= in_data;
  end

  // A held skid entry always sits behind a held main entry.
  always @(negedge clk) begin
    if (!reset && !in_ready && !out_valid) begin
      nvec++;
      nfail++;
      $display("FAIL skid_implies_main: in_ready=%0b out_valid=%0b required out_valid=1",
               in_ready, out_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 'h55; out_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    nvec++; if (out_data !== '0) begin nfail++; $display("FAIL rst_out_data: got %0h required 0", out_data); end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %0b required 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_release_valid: got %0b required 0", out_valid); end
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = W'(k);
      tick();
      nvec++; if (out_valid !== 1'b1 || out_data !== W'(k)) begin
        nfail++; $display("FAIL thr_beat%0d: valid=%0b data=%0h required valid=1 data=%0h", k, out_valid, out_data, k);
      end
      nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL thr_ready%0d: got %0b required 1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL thr_drain: out_valid=%0b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'hA;
    tick();
    nvec++; if (in_ready !== 1'b1 || out_data !== 'hA) begin
      nfail++; $display("FAIL bp_first: in_ready=%0b data=%0h required 1/a", in_ready, out_data);
    end
    in_data = 'hB;
    tick();
    in_valid = 1'b0;
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_full_ready: got %0b required 0", in_ready); end
    tick();
    nvec++; if (out_valid !== 1'b1 || out_data !== 'hA) begin
      nfail++; $display("FAIL bp_hold: valid=%0b data=%0h required 1/a", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    nvec++; if (out_valid !== 1'b1 || out_data !== 'hB || in_ready !== 1'b1) begin
      nfail++; $display("FAIL bp_skid_out: valid=%0b data=%0h ready=%0b required 1/b/1", out_valid, out_data, in_ready);
    end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL bp_drain: out_valid=%0b required 0", out_valid); end
  endtask

  task automatic test_flush_full();
    logic [W-1:0] ones;
    ones = '1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = ones;          // main, bit0 = 1
    tick();
    in_data = ones << 1;                                          // skid, bit0 = 0
    tick();
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL fl_full_setup: in_ready=%0b required 0", in_ready); end
    flush = 1'b1; in_data = 'h7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL fl_valid: got %0b required 0", out_valid); end
    nvec++; if (out_data !== 'h1) begin nfail++; $display("FAIL fl_data: got %0h required 1", out_data); end
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL fl_ready: got %0b required 1", in_ready); end
    out_ready = 1'b1;
    tick();
    nvec++; if (out_valid !== 1'b0 || out_data !== 'h1) begin
      nfail++; $display("FAIL fl_no_capture: valid=%0b data=%0h required 0/1", out_valid, out_data);
    end
  endtask

  task automatic test_flush_outfire();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 'h9;
    tick();
    nvec++; if (out_valid !== 1'b1 || out_data !== 'h9) begin
      nfail++; $display("FAIL fo_setup: valid=%0b data=%0h required 1/9", out_valid, out_data);
    end
    in_data = 'hC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL fo_empty: out_valid=%0b required 0", out_valid); end
    nvec++; if (out_data !== 'h1) begin nfail++; $display("FAIL fo_data: got %0h required 1", out_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL fo_no_dup%0d: out_valid=%0b required 0", k, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    // Alternating backpressure: every payload must appear once, in order.
    logic [7:0] got [$];
    int         sent;
    sent = 0;
    in_valid = 1'b1; in_data = W'(8'h20);
    for (int cyc = 0; cyc < 24; cyc++) begin
      out_ready = cyc[0];
      @(posedge clk);
      if (out_valid && out_ready) got.push_back(out_data[7:0]);
      if (in_valid && in_ready) sent++;
      #1;
      in_valid = (sent < 6);
      in_data  = W'(8'h20 + sent);
    end
    in_valid = 1'b0;
    nvec++; if (got.size() != 6) begin nfail++; $display("FAIL b2b_count: got %0d beats required 6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      nvec++; if (got[k] !== 8'(8'h20 + k)) begin nfail++; $display("FAIL b2b_order%0d: got %0h required %0h", k, got[k], 8'h20 + k); end
    end
    out_ready = 1'b1;
    tick(); tick();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    reset = 1'b0;
    nvec++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      nfail++; $display("FAIL perf_reset: stall=%0d flush=%0d required 0/0", stall_cycles, flush_count);
    end
    in_valid = 1'b1; in_data = 'h1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    nvec++; if (stall_cycles !== 32'd5) begin nfail++; $display("FAIL perf_stall: got %0d required 5", stall_cycles); end
    out_ready = 1'b1; flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    nvec++; if (flush_count !== 32'd1) begin nfail++; $display("FAIL perf_flush: got %0d required 1", flush_count); end
    nvec++; if (stall_cycles !== 32'd5) begin nfail++; $display("FAIL perf_stall_hold: got %0d required 5", stall_cycles); end
    force u_dut.u_stall_cnt.count = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_stall_cnt.count;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h2;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    nvec++; if (stall_cycles !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL perf_sat: got %0h required ffffffff", stall_cycles); end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_throughput();
    test_backpressure();
    test_flush_full();
    test_flush_outfire();
    test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
